// File: rtl/tomasulo_pkg.sv
// ---------------------------------------------------------------------------
// tomasulo_pkg
//   Shared definitions for the back-end result-broadcast cluster.
//   - TAG_W / DATA_W   : default ROB/RS tag and result data widths
//   - REQ_*            : requester index assignment on the common data bus
//   - cdb_pkt_t        : one result as it travels from an execution unit to
//                        the CDB ({tag, data})
//   - rr_index/rr_next : round-robin index helpers used by the arbiter
// ---------------------------------------------------------------------------
package tomasulo_pkg;

    localparam int TAG_W  = 6;
    localparam int DATA_W = 32;

    // Requester slots on the CDB arbiter
    localparam int REQ_ALU = 0;
    localparam int REQ_MUL = 1;
    localparam int REQ_DIV = 2;
    localparam int REQ_AGU = 3;

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } cdb_pkt_t;

    // Index visited at step 'offs' of a circular search that starts at 'base'.
    function automatic int rr_index(input int base, input int offs, input int n);
        return (base + offs) % n;
    endfunction

    // Pointer value after 'winner' has been granted; wraps n-1 -> 0.
    function automatic int rr_next(input int winner, input int n);
        return (winner == n - 1) ? 0 : winner + 1;
    endfunction

endpackage

// File: rtl/cdb_req_fifo.sv
// ---------------------------------------------------------------------------
// cdb_req_fifo
//   Small synchronous FIFO holding results of one requester until the CDB
//   arbiter grants it. Storage is a register array so the head entry is
//   readable in the same cycle the arbiter makes its decision.
//
//   Ports
//     clk       : clock, all state on rising edge
//     rst       : synchronous active-low reset (empties the FIFO)
//     flush     : synchronous discard of all entries; wins over push/pop
//     push      : write push_pkt (ignored when full)
//     push_pkt  : entry to write
//     pop       : drop head entry (ignored when empty)
//     head_pkt  : oldest entry (valid when !empty)
//     full      : count == DEPTH
//     empty     : count == 0
//     count     : number of stored entries, 0..DEPTH
// ---------------------------------------------------------------------------
module cdb_req_fifo #(
    parameter type pkt_t = tomasulo_pkg::cdb_pkt_t,
    parameter int  DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   push,
    input  pkt_t                   push_pkt,
    input  logic                   pop,
    output pkt_t                   head_pkt,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    pkt_t             mem_reg [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;

    logic do_push;
    logic do_pop;

    assign full     = (count_reg == CNT_W'(DEPTH));
    assign empty    = (count_reg == '0);
    assign count    = count_reg;
    assign head_pkt = mem_reg[rd_ptr_reg];

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointers are power-of-two wide, so they wrap without explicit compare.
    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Storage needs no reset: empty/count gate every use of the contents.
    always_ff @(posedge clk) begin
        if (rst && !flush && do_push) begin
            mem_reg[wr_ptr_reg] <= push_pkt;
        end
    end

endmodule

// File: rtl/tomasulo_cdb_arbiter.sv
// ---------------------------------------------------------------------------
// tomasulo_cdb_arbiter
//   Schedules functional-unit results onto the single common data bus.
//   Every requester owns a private cdb_req_fifo fed through valid/ready.
//   A round-robin arbiter picks one non-empty FIFO per cycle, pops its head
//   and registers it onto the CDB broadcast outputs.
//
//   Ports
//     clk        : clock, all state on rising edge
//     rst        : synchronous active-low reset
//     flush      : discard every pending result (mispredict/abort)
//     req_valid  : [N_REQ]        requester i offers a result
//     req_ready  : [N_REQ]        requester i FIFO can accept (registered count only)
//     req_tag    : [N_REQ*TAG_W]  tag of requester i at [i*TAG_W +: TAG_W]
//     req_data   : [N_REQ*DATA_W] data of requester i at [i*DATA_W +: DATA_W]
//     cdb_valid  : broadcast valid this cycle
//     cdb_tag    : broadcast tag   (holds last value while invalid)
//     cdb_data   : broadcast data  (holds last value while invalid)
//     cdb_src    : winning requester index (holds last value while invalid)
//     busy       : any FIFO non-empty or broadcast in progress
// ---------------------------------------------------------------------------
module tomasulo_cdb_arbiter #(
    parameter int N_REQ      = 4,
    parameter int TAG_W      = tomasulo_pkg::TAG_W,
    parameter int DATA_W     = tomasulo_pkg::DATA_W,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic [N_REQ-1:0]           req_valid,
    output logic [N_REQ-1:0]           req_ready,
    input  logic [N_REQ*TAG_W-1:0]     req_tag,
    input  logic [N_REQ*DATA_W-1:0]    req_data,
    output logic                       cdb_valid,
    output logic [TAG_W-1:0]           cdb_tag,
    output logic [DATA_W-1:0]          cdb_data,
    output logic [$clog2(N_REQ)-1:0]   cdb_src,
    output logic                       busy
);

    import tomasulo_pkg::*;

    localparam int IDX_W = $clog2(N_REQ);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    // Same layout as cdb_pkt_t, but following this instance's widths.
    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } bus_pkt_t;

    logic [N_REQ-1:0] fifo_push;
    logic [N_REQ-1:0] fifo_pop;
    logic [N_REQ-1:0] fifo_full;
    logic [N_REQ-1:0] fifo_empty;
    logic [N_REQ-1:0] fifo_nonempty;
    logic [CNT_W-1:0] fifo_count [N_REQ];
    bus_pkt_t         head_pkt   [N_REQ];

    logic             grant_valid;
    logic [IDX_W-1:0] grant_idx;
    bus_pkt_t         grant_pkt;

    logic [IDX_W-1:0]  rr_ptr_reg;
    logic              cdb_valid_reg;
    logic [TAG_W-1:0]  cdb_tag_reg;
    logic [DATA_W-1:0] cdb_data_reg;
    logic [IDX_W-1:0]  cdb_src_reg;

    // -----------------------------------------------------------------------
    // Per-requester FIFOs
    // -----------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_req
            bus_pkt_t push_pkt;

            assign push_pkt.tag  = req_tag[gi*TAG_W +: TAG_W];
            assign push_pkt.data = req_data[gi*DATA_W +: DATA_W];

            // Ready looks only at the registered fill level, never at this
            // cycle's grant, so there is no combinational valid->ready path.
            assign req_ready[gi] = !fifo_full[gi] && rst && !flush;
            assign fifo_push[gi] = req_valid[gi] && req_ready[gi];
            assign fifo_pop[gi]  = grant_valid && (grant_idx == IDX_W'(gi)) && !flush;
            assign fifo_nonempty[gi] = (fifo_count[gi] != '0);

            cdb_req_fifo #(
                .pkt_t (bus_pkt_t),
                .DEPTH (FIFO_DEPTH)
            ) u_fifo (
                .clk      (clk),
                .rst      (rst),
                .flush    (flush),
                .push     (fifo_push[gi]),
                .push_pkt (push_pkt),
                .pop      (fifo_pop[gi]),
                .head_pkt (head_pkt[gi]),
                .full     (fifo_full[gi]),
                .empty    (fifo_empty[gi]),
                .count    (fifo_count[gi])
            );
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Round-robin search: start at rr_ptr_reg, first non-empty FIFO wins.
    // -----------------------------------------------------------------------
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!grant_valid && !fifo_empty[rr_index(int'(rr_ptr_reg), k, N_REQ)]) begin
                grant_valid = 1'b1;
                grant_idx   = IDX_W'(rr_index(int'(rr_ptr_reg), k, N_REQ));
            end
        end
    end

    assign grant_pkt = head_pkt[grant_idx];

    // -----------------------------------------------------------------------
    // Pointer and registered CDB broadcast. Flush only kills the valid and
    // rewinds the pointer; a broadcast already on the bus this cycle is left
    // alone because it was registered before the flush arrived.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            rr_ptr_reg    <= '0;
            cdb_valid_reg <= 1'b0;
            cdb_tag_reg   <= '0;
            cdb_data_reg  <= '0;
            cdb_src_reg   <= '0;
        end else if (flush) begin
            rr_ptr_reg    <= '0;
            cdb_valid_reg <= 1'b0;
        end else if (grant_valid) begin
            rr_ptr_reg    <= IDX_W'(rr_next(int'(grant_idx), N_REQ));
            cdb_valid_reg <= 1'b1;
            cdb_tag_reg   <= grant_pkt.tag;
            cdb_data_reg  <= grant_pkt.data;
            cdb_src_reg   <= grant_idx;
        end else begin
            cdb_valid_reg <= 1'b0;
        end
    end

    assign cdb_valid = cdb_valid_reg;
    assign cdb_tag   = cdb_tag_reg;
    assign cdb_data  = cdb_data_reg;
    assign cdb_src   = cdb_src_reg;
    assign busy      = (|fifo_nonempty) || cdb_valid_reg;

endmodule

// File: tb/tb_tomasulo_cdb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_tomasulo_cdb_arbiter
//   Self-checking bench for tomasulo_cdb_arbiter. Each accepted push is
//   recorded in a scoreboard queue; each CDB broadcast is matched against the
//   oldest outstanding entry of the same requester. Directed checks cover
//   reset, latency, arbitration order, backpressure, flush and mid-run reset.
// ---------------------------------------------------------------------------
module tb_tomasulo_cdb_arbiter;
    import tomasulo_pkg::*;

    localparam int N = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            flush;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*6-1:0]  req_tag;
    logic [N*32-1:0] req_data;
    logic            cdb_valid;
    logic [5:0]      cdb_tag;
    logic [31:0]     cdb_data;
    logic [1:0]      cdb_src;
    logic            busy;

    always #5 clk = ~clk;

    tomasulo_cdb_arbiter #(
        .N_REQ      (4),
        .TAG_W      (6),
        .DATA_W     (32),
        .FIFO_DEPTH (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_tag   (req_tag),
        .req_data  (req_data),
        .cdb_valid (cdb_valid),
        .cdb_tag   (cdb_tag),
        .cdb_data  (cdb_data),
        .cdb_src   (cdb_src),
        .busy      (busy)
    );

    typedef struct packed {
        logic [1:0] src;
        cdb_pkt_t   pkt;
    } sb_t;

    sb_t        sb_q[$];
    logic [1:0] src_log[$];

    int total = 0;
    int bad   = 0;

    int         rem      [N];
    int         seq      [N];
    logic [5:0] cur_tag  [N];
    logic [31:0] cur_data[N];
    logic       acc      [N];
    logic       rst_want;
    logic       flush_want;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Scoreboard monitor: compare broadcasts, then drop on flush/reset,
    // then record pushes that the next edge will accept.
    always @(negedge clk) begin
        if (cdb_valid === 1'b1) begin
            int hit;
            hit = -1;
            for (int k = 0; k < sb_q.size(); k++) begin
                if (hit < 0 && sb_q[k].src == cdb_src) hit = k;
            end
            src_log.push_back(cdb_src);
            $display("cdb src=%0d tag=%02h data=%08h", cdb_src, cdb_tag, cdb_data);
            chk("sb_hit", 64'(hit >= 0), 64'd1);
            if (hit >= 0) begin
                chk("sb_tag", 64'(cdb_tag), 64'(sb_q[hit].pkt.tag));
                chk("sb_data", 64'(cdb_data), 64'(sb_q[hit].pkt.data));
                sb_q.delete(hit);
            end
        end
        if (flush === 1'b1 || rst !== 1'b1) begin
            sb_q.delete();
        end else begin
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    sb_t e;
                    e.src      = 2'(i);
                    e.pkt.tag  = req_tag[i*6 +: 6];
                    e.pkt.data = req_data[i*32 +: 32];
                    sb_q.push_back(e);
                end
            end
        end
    end

    // One clock: drive after the rising edge, sample handshakes after the
    // falling edge. Requester i keeps offering while rem[i] > 0.
    task automatic one_cycle();
        @(posedge clk);
        #1;
        rst   = rst_want;
        flush = flush_want;
        for (int i = 0; i < N; i++) begin
            if (acc[i]) begin
                seq[i]++;
                if (rem[i] > 0) rem[i]--;
                cur_tag[i]  = {2'(i), 4'(seq[i])};
                cur_data[i] = $urandom;
            end
            req_valid[i]       = (rem[i] > 0);
            req_tag[i*6 +: 6]  = cur_tag[i];
            req_data[i*32 +: 32] = cur_data[i];
        end
        @(negedge clk);
        #1;
        for (int i = 0; i < N; i++) acc[i] = req_valid[i] && req_ready[i];
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 50) begin
            one_cycle();
            n++;
        end
        chk({tag, "_idle"}, 64'(busy), 64'd0);
        chk({tag, "_sb_empty"}, 64'(sb_q.size()), 64'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int t4_exp[10] = '{2, 3, 1, 3, 1, 3, 1, 3, 1, 3};

        rst = 1'b0; flush = 1'b0; req_valid = '0; req_tag = '0; req_data = '0;
        rst_want = 1'b0; flush_want = 1'b0;
        for (int i = 0; i < N; i++) begin
            rem[i] = 0; seq[i] = 0; cur_tag[i] = {2'(i), 4'd0}; cur_data[i] = '0; acc[i] = 1'b0;
        end

        // 1: reset held with all requesters offering
        for (int i = 0; i < N; i++) rem[i] = 1000;
        repeat (3) one_cycle();
        chk("t1_ready", 64'(req_ready), 64'h0);
        chk("t1_cdb_valid", 64'(cdb_valid), 64'd0);
        chk("t1_busy", 64'(busy), 64'd0);
        for (int i = 0; i < N; i++) rem[i] = 0;
        rst_want = 1'b1;
        one_cycle();
        chk("t1_ready_rel", 64'(req_ready), 64'hF);

        // 2: single ALU result, latency
        cur_tag[0] = 6'h05; cur_data[0] = 32'hDEADBEEF; rem[0] = 1;
        one_cycle();                          // offer
        one_cycle();                          // accepted at this edge
        chk("t2_early_valid", 64'(cdb_valid), 64'd0);
        one_cycle();                          // broadcast registered
        chk("t2_valid", 64'(cdb_valid), 64'd1);
        chk("t2_tag", 64'(cdb_tag), 64'h05);
        chk("t2_data", 64'(cdb_data), 64'hDEADBEEF);
        chk("t2_src", 64'(cdb_src), 64'd0);
        one_cycle();
        chk("t2_late_valid", 64'(cdb_valid), 64'd0);
        drain("t2");

        // 3: all four push on one edge, pointer rewound by a flush first
        flush_want = 1'b1; one_cycle(); flush_want = 1'b0;
        for (int i = 0; i < N; i++) rem[i] = 1;
        one_cycle();
        one_cycle();
        chk("t3_gap0", 64'(cdb_valid), 64'd0);
        for (int k = 0; k < N; k++) begin
            one_cycle();
            chk($sformatf("t3_valid%0d", k), 64'(cdb_valid), 64'd1);
            chk($sformatf("t3_src%0d", k), 64'(cdb_src), 64'(k));
        end
        one_cycle();
        chk("t3_after", 64'(cdb_valid), 64'd0);
        drain("t3");

        // 4: DIV moves pointer to 3, then MUL and AGU push continuously
        src_log.delete();
        rem[2] = 1;
        one_cycle();
        rem[1] = 40; rem[3] = 40;
        repeat (12) one_cycle();
        rem[1] = 0; rem[3] = 0;
        drain("t4");
        chk("t4_len_ok", 64'(src_log.size() >= 10), 64'd1);
        for (int k = 0; k < 10 && k < src_log.size(); k++) begin
            chk($sformatf("t4_order%0d", k), 64'(src_log[k]), 64'(t4_exp[k]));
        end

        // 5: DIV backpressure behind ALU and MUL
        flush_want = 1'b1; one_cycle(); flush_want = 1'b0;
        rem[0] = 1; rem[1] = 1; rem[2] = 3;
        one_cycle();                          // offer
        one_cycle();                          // ALU, MUL, DIV#1 stored
        one_cycle();                          // DIV#2 stored, ALU granted
        chk("t5_full", 64'(req_ready[2]), 64'd0);
        one_cycle();                          // MUL granted, DIV full and popped next
        chk("t5_full_pop", 64'(req_ready[2]), 64'd0);
        one_cycle();                          // DIV granted
        chk("t5_ready_again", 64'(req_ready[2]), 64'd1);
        chk("t5_src", 64'(cdb_src), 64'd2);
        drain("t5");

        // 6: flush with five entries held and an ALU push in the flush cycle
        flush_want = 1'b1; one_cycle(); flush_want = 1'b0;
        for (int i = 0; i < N; i++) rem[i] = 2;
        one_cycle();
        one_cycle();
        one_cycle();
        one_cycle();
        flush_want = 1'b1; rem[0] = 1;
        one_cycle();
        chk("t6_visible", 64'(cdb_valid), 64'd1);
        chk("t6_ready", 64'(req_ready), 64'h0);
        flush_want = 1'b0; rem[0] = 0;
        one_cycle();
        chk("t6_valid", 64'(cdb_valid), 64'd0);
        chk("t6_busy", 64'(busy), 64'd0);
        rem[1] = 1; rem[3] = 1;
        one_cycle();
        one_cycle();
        one_cycle();
        chk("t6_rr_first", 64'(cdb_src), 64'd1);
        one_cycle();
        chk("t6_rr_second", 64'(cdb_src), 64'd3);
        drain("t6");

        // 7: reset in the middle of traffic
        for (int i = 0; i < N; i++) rem[i] = 1;
        one_cycle();
        one_cycle();
        rst_want = 1'b0;
        one_cycle();
        one_cycle();
        chk("t7_valid", 64'(cdb_valid), 64'd0);
        chk("t7_busy", 64'(busy), 64'd0);
        rst_want = 1'b1;
        one_cycle();
        chk("t7_ready", 64'(req_ready), 64'hF);
        drain("t7");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
